output_port_allocator: RTL and testbench
========================================

Name: output_port_allocator

Overview:
- Per-output-port packet-level allocation controller in the router, wrapped around the matrix arbiter for one output port.
- Collects head-flit requests from the CHANNELS input buffers and drives the arbiter request vector.
- Consumes the one-hot grant, locks the output to the winner until its tail flit passes, and drives the crossbar select and input-buffer pops.
- Tracks downstream buffer credits and never sends a flit without a credit.

Parameters:
CHANNELS, 5, number of input ports competing for this output; equals the arbiter width.
CREDITS, 4, downstream input-buffer depth in flits; credit counter reset value.
CNT_W, 3, credit counter width; must satisfy 2^CNT_W > CREDITS.

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  reset; synchronous, active-high
in_valid  input  CHANNELS  input buffer i has a flit at its head
in_head  input  CHANNELS  flit at buffer i head is a head flit
in_tail  input  CHANNELS  flit at buffer i head is a tail flit (head+tail = single-flit packet)
in_pop  output  CHANNELS  one-hot/zero; dequeue buffer i this cycle
arb_request  output  CHANNELS  request vector to the matrix arbiter
arb_grant  input  CHANNELS  combinational one-hot/zero grant from the arbiter, same cycle
xbar_sel  output  CHANNELS  one-hot/zero crossbar select for this output
out_valid  output  1  flit leaves on this output this cycle
credit_in  input  1  downstream freed one buffer slot
credit_count  output  CNT_W  current credits
locked  output  1  output is held by a packet in progress

Behaviour:
- Reset (RST=1 at clock edge):
  - state=IDLE, owner=0, credit_count=CREDITS.
  - All combinational outputs then evaluate to 0.
  - The arbiter shares RST, so its priority matrix is reset in the same edge.
- A transfer is a cycle in which out_valid=1. Every transfer asserts exactly one in_pop bit and the same xbar_sel bit.
- Latency:
  - 0 cycles from a valid head request to pop/out_valid when credits are available.
  - The arbiter resolves combinationally.
- IDLE state:
  - arb_request = in_valid & in_head if credit_count != 0, else 0.
  - When arb_grant = g (one-hot): transfer from g (in_pop=g, xbar_sel=g, out_valid=1) and latch owner=g.
    - in_tail[g]=1 (single-flit packet): stay IDLE.
    - Otherwise: go to LOCKED.
  - When arb_grant=0: no action.
  - Valid flits that are not head flits are never requested in IDLE.
- LOCKED state:
  - arb_request=0, so the arbiter updates its priority exactly once per packet, on the head grant.
  - A transfer happens when in_valid[owner]=1 and credit_count != 0; in_pop=xbar_sel=owner.
  - in_head is ignored in LOCKED; every flit from the owner is forwarded as a body flit.
  - A transferred flit with in_tail[owner]=1 returns the state to IDLE on the next edge.
  - The next packet's arbitration starts in the following cycle, so there is a minimum one-cycle gap.
  - An owner with no valid flit (bubble) keeps the lock with no timeout.
- locked = 1 exactly when state=LOCKED (registered).
- Credits, updated on each clock edge:
  - Transfer without credit_in: decrement by 1.
  - credit_in without transfer: increment by 1.
  - Both in the same cycle: unchanged.
  - credit_in while credit_count=CREDITS: saturate at CREDITS; this is a protocol error and produces no other side effect.
  - No transfer is allowed when credit_count=0, including in the cycle credit_in arrives; the new credit is usable from the next cycle.
- A non-one-hot arb_grant is illegal; the block's behaviour under it is unspecified. The bench flags it with an assertion.
- RST asserted mid-packet drops ownership immediately.
  - The remaining body flits in the owner buffer are then non-head flits and stay stalled until flushed by upstream reset.

Test Plan:
- Reset, then in_valid=in_head=5'b00100 with in_tail=0 → same cycle arb_request=5'b00100, in_pop=xbar_sel=5'b00100, out_valid=1; next cycle locked=1, credit_count=3.
- 3-flit packet on port 2 with port 0 requesting a head throughout → port 0 never popped until cycle after port 2 tail; then port 0 granted, locked back to 1.
- Two simultaneous requesters (ports 1, 3) sending single-flit packets repeatedly → grants alternate 1,3,1,3 per matrix LRU; locked stays 0.
- 6-flit packet, credit_in held 0 → exactly 4 transfers, then out_valid=0 with credit_count=0; pulse credit_in once → one more transfer the following cycle, credit_count back to 0.
- Transfer and credit_in in the same cycle at credit_count=2 → credit_count stays 2; credit_in at credit_count=4 → stays 4.
- RST mid-packet (owner 4, after 2 flits) → next cycle locked=0, credit_count=4, all outputs 0; a new head on port 0 is granted immediately.

Source files
------------

// File: rtl/output_port_allocator.sv
// Packet-level allocator for one router output port.
// Drives the matrix arbiter, holds the output per packet and tracks credits.
module output_port_allocator #(
    parameter int CHANNELS = 5,
    parameter int CREDITS  = 4,
    parameter int CNT_W    = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CHANNELS-1:0] in_valid,
    input  logic [CHANNELS-1:0] in_head,
    input  logic [CHANNELS-1:0] in_tail,
    output logic [CHANNELS-1:0] in_pop,
    output logic [CHANNELS-1:0] arb_request,
    input  logic [CHANNELS-1:0] arb_grant,
    output logic [CHANNELS-1:0] xbar_sel,
    output logic                out_valid,
    input  logic                credit_in,
    output logic [CNT_W-1:0]    credit_count,
    output logic                locked
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

    state_t              state_q, state_d;
    logic [CHANNELS-1:0] owner_q, owner_d;
    logic [CNT_W-1:0]    credit_q, credit_d;
    logic [CHANNELS-1:0] sel;
    logic                has_credit;
    logic                xfer;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            credit_q <= CRED_MAX;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            credit_q <= credit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        sel         = '0;
        arb_request = '0;
        has_credit  = (credit_q != '0);
        unique case (state_q)
            IDLE: begin
                if (has_credit) begin
                    arb_request = in_valid & in_head;
                end
                // Only honour a grant for a line we actually requested.
                if (|(arb_grant & arb_request)) begin
                    sel     = arb_grant & arb_request;
                    owner_d = sel;
                    if (!(|(sel & in_tail))) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (has_credit && |(owner_q & in_valid)) begin
                    sel = owner_q;
                    if (|(owner_q & in_tail)) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
        // Reset drops the lock at once: nothing may leave during it.
        if (RST) begin
            arb_request = '0;
            sel         = '0;
        end
    end

    assign xfer = |sel;

    always_comb begin
        credit_d = credit_q;
        if (xfer && !credit_in) begin
            credit_d = credit_q - 1'b1;
        end else if (!xfer && credit_in && credit_q != CRED_MAX) begin
            credit_d = credit_q + 1'b1;
        end
    end

    assign in_pop       = sel;
    assign xbar_sel     = sel;
    assign out_valid    = xfer;
    assign credit_count = credit_q;
    assign locked       = (state_q == LOCKED);

endmodule

// File: tb/tb_output_port_allocator.sv
// Randomised bench for output_port_allocator with an LRU arbiter model
// and a packet-level reference model of ownership and credits.
module tb_output_port_allocator;

    localparam int CH  = 5;
    localparam int CR  = 4;
    localparam int CW  = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic [CH-1:0] in_valid, in_head, in_tail;
    logic [CH-1:0] in_pop, arb_request, arb_grant, xbar_sel;
    logic          out_valid, credit_in, locked;
    logic [CW-1:0] credit_count;

    output_port_allocator #(.CHANNELS(CH), .CREDITS(CR), .CNT_W(CW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_valid    (in_valid),
        .in_head     (in_head),
        .in_tail     (in_tail),
        .in_pop      (in_pop),
        .arb_request (arb_request),
        .arb_grant   (arb_grant),
        .xbar_sel    (xbar_sel),
        .out_valid   (out_valid),
        .credit_in   (credit_in),
        .credit_count(credit_count),
        .locked      (locked)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: plain integers, not the RTL encoding.
    bit            m_locked;
    int            m_owner;
    int            m_cred;
    int            prio[$];
    logic [CH-1:0] last_pop;

    // Packet sources for the random phase.
    int len[CH];
    int pos[CH];

    always @(posedge CLK) begin
        if (!RST) begin
            assert ($onehot0(arb_grant))
            else $error("illegal non-one-hot arb_grant %b", arb_grant);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_locked = 1'b0;
        m_owner  = 0;
        m_cred   = CR;
        prio     = {0, 1, 2, 3, 4};
    endtask

    task automatic step(input logic r, input logic [CH-1:0] v,
                        input logic [CH-1:0] h, input logic [CH-1:0] t,
                        input logic cin);
        int            gi;
        logic [CH-1:0] one;
        logic [CH-1:0] exp_req, exp_sel;
        @(negedge CLK);
        RST       = r;
        in_valid  = v;
        in_head   = h;
        in_tail   = t;
        credit_in = cin;
        arb_grant = '0;
        #1;
        // LRU arbiter environment: first requester in priority order wins.
        gi = -1;
        if (!r) begin
            for (int k = 0; k < prio.size(); k++) begin
                if (gi < 0 && arb_request[prio[k]]) gi = prio[k];
            end
        end
        one       = 1;
        arb_grant = (gi >= 0) ? (one << gi) : '0;
        #1;
        exp_req = '0;
        exp_sel = '0;
        if (!r) begin
            if (!m_locked) begin
                if (m_cred > 0) exp_req = v & h;
                if (gi >= 0 && exp_req[gi]) exp_sel = one << gi;
            end else if (v[m_owner] && m_cred > 0) begin
                exp_sel = one << m_owner;
            end
        end
        check("arb_request", 32'(arb_request), 32'(exp_req));
        check("in_pop", 32'(in_pop), 32'(exp_sel));
        check("xbar_sel", 32'(xbar_sel), 32'(exp_sel));
        check("out_valid", 32'(out_valid), 32'(|exp_sel));
        check("locked", 32'(locked), 32'(m_locked));
        check("credit_count", 32'(credit_count), 32'(m_cred));
        last_pop = exp_sel;
        if (r) begin
            reset_model();
        end else begin
            if (!m_locked && |exp_sel) begin
                m_owner  = gi;
                m_locked = !t[gi];
            end else if (m_locked && |exp_sel && t[m_owner]) begin
                m_locked = 1'b0;
            end
            if (|exp_sel && !cin) m_cred--;
            else if (!(|exp_sel) && cin && m_cred < CR) m_cred++;
            if (gi >= 0) begin
                for (int k = 0; k < prio.size(); k++) begin
                    if (prio[k] == gi) begin
                        prio.delete(k);
                        break;
                    end
                end
                prio.push_back(gi);
            end
        end
    endtask

    task automatic new_pkt(input int i);
        len[i] = $urandom_range(1, 6);
        pos[i] = 0;
    endtask

    initial begin
        logic [CH-1:0] v, h, t;
        logic          r, cin;
        int            occ;
        RST       = 1'b1;
        in_valid  = '0;
        in_head   = '0;
        in_tail   = '0;
        credit_in = 1'b0;
        arb_grant = '0;
        reset_model();
        last_pop  = '0;

        // Reset, then a head on port 2 goes out in the same cycle.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 5'b00100, 5'b00100, 5'b00000, 0);
        // Port 2 body and tail while port 0 holds a head.
        step(0, 5'b00101, 5'b00001, 5'b00000, 0);
        step(0, 5'b00101, 5'b00001, 5'b00100, 1);
        step(0, 5'b00001, 5'b00001, 5'b00000, 0);
        step(0, 5'b00001, 5'b00000, 5'b00001, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Ports 1 and 3 with single-flit packets alternate.
        for (int i = 0; i < 6; i++) step(0, 5'b01010, 5'b01010, 5'b01010, 1);
        step(0, 0, 0, 0, 0);

        // 6-flit packet with no returning credits stalls after 4 flits.
        step(1, 0, 0, 0, 0);
        step(0, 5'b00001, 5'b00001, 5'b00000, 0);
        for (int i = 0; i < 4; i++) step(0, 5'b00001, 5'b00000, 5'b00000, 0);
        step(0, 5'b00001, 5'b00000, 5'b00000, 1);
        step(0, 5'b00001, 5'b00000, 5'b00000, 0);
        step(0, 5'b00001, 5'b00000, 5'b00001, 1);
        step(0, 5'b00001, 5'b00000, 5'b00001, 0);
        step(0, 0, 0, 0, 0);

        // Transfer and credit together at 2, then saturation at 4.
        step(1, 0, 0, 0, 0);
        step(0, 5'b00010, 5'b00010, 5'b00000, 0);
        step(0, 5'b00010, 5'b00000, 5'b00000, 0);
        step(0, 5'b00010, 5'b00000, 5'b00010, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Reset in the middle of a port 4 packet.
        step(0, 5'b10000, 5'b10000, 5'b00000, 0);
        step(0, 5'b10000, 5'b00000, 5'b00000, 0);
        step(1, 5'b10000, 5'b00000, 5'b00000, 0);
        step(0, 5'b00000, 5'b00000, 5'b00000, 0);
        step(0, 5'b10001, 5'b00001, 5'b00001, 0);
        step(0, 0, 0, 0, 1);

        // Random packet traffic with random credit returns.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < CH; i++) new_pkt(i);
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < CH; i++) begin
                v[i] = ($urandom_range(0, 3) != 0);
                h[i] = (pos[i] == 0);
                t[i] = (pos[i] == len[i] - 1);
            end
            occ = CR - m_cred;
            cin = (occ > 0) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 49) == 0);
            step(r, v, h, t, cin);
            if (r) begin
                for (int i = 0; i < CH; i++) new_pkt(i);
            end else begin
                for (int i = 0; i < CH; i++) begin
                    if (last_pop[i]) begin
                        pos[i]++;
                        if (pos[i] == len[i]) new_pkt(i);
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
